// File: rtl/interrupt_acknowledge_sequencer_pkg.sv
// Shared types and helpers for the 8259A interrupt acknowledge sequencer.
// Level priority is relative to priority_rotate (the lowest-priority level).
package interrupt_acknowledge_sequencer_pkg;

  localparam int LEVELS = 8;

  localparam logic [2:0] EOI_NONSPEC  = 3'b001;
  localparam logic [2:0] EOI_SPEC     = 3'b011;
  localparam logic [2:0] ROT_NONSPEC  = 3'b101;
  localparam logic [2:0] ROT_SPEC     = 3'b111;
  localparam logic [2:0] SET_PRIO     = 3'b110;
  localparam logic [2:0] AEOI_ROT_SET = 3'b100;
  localparam logic [2:0] AEOI_ROT_CLR = 3'b000;

  typedef enum logic [1:0] {
    IDLE,
    ACK1,
    WAIT2,
    ACK2
  } state_e;

  function automatic logic [7:0] rotate_right(
    input logic [7:0] v,
    input logic [2:0] n
  );
    logic [15:0] d;
    d = {v, v};
    return d[n +: 8];
  endfunction

  function automatic logic [7:0] rotate_left(
    input logic [7:0] v,
    input logic [2:0] n
  );
    logic [15:0] d;
    logic [3:0]  s;
    d = {v, v};
    s = 4'd8 - {1'b0, n};
    return d[s +: 8];
  endfunction

  function automatic logic [7:0] resolv_priority(
    input logic [7:0] v
  );
    return v & (~v + 8'd1);
  endfunction

  function automatic logic [2:0] onehot_to_level(
    input logic [7:0] v
  );
    logic [2:0] l;
    l = '0;
    for (int i = 0; i < LEVELS; i++)
      if (v[i]) l = 3'(i);
    return l;
  endfunction

  function automatic logic [2:0] level_priority(
    input logic [2:0] lvl,
    input logic [2:0] rot
  );
    return lvl - rot - 3'd1;
  endfunction

endpackage

// File: rtl/interrupt_acknowledge_sequencer_priority_resolver.sv
// Masks a request vector and returns the one-hot winner under the
// current rotation (level rotate_i+1 is highest priority).
import interrupt_acknowledge_sequencer_pkg::*;

module priority_resolver (
  input  logic [7:0] request_i,
  input  logic [7:0] mask_i,
  input  logic [2:0] rotate_i,
  output logic [7:0] grant_o
);

  logic [2:0] shift;

  assign shift   = rotate_i + 3'd1;
  assign grant_o = rotate_left(
    resolv_priority(rotate_right(request_i & ~mask_i, shift)), shift);

endmodule

// File: rtl/interrupt_acknowledge_sequencer.sv
// In-service side of the 8259A: INTA handshake, vector drive,
// EOI/AEOI clearing and priority rotation state.
import interrupt_acknowledge_sequencer_pkg::*;

module interrupt_acknowledge_sequencer #(
  parameter int NUM_LEVELS = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  interrupt_acknowledge_n,
  input  logic [NUM_LEVELS-1:0] interrupt_request_register,
  input  logic [NUM_LEVELS-1:0] interrupt_mask,
  input  logic                  special_mask_mode,
  input  logic                  auto_eoi_config,
  input  logic [4:0]            vector_base,
  input  logic                  ocw2_write,
  input  logic [2:0]            ocw2_command,
  input  logic [2:0]            ocw2_level,
  output logic [NUM_LEVELS-1:0] in_service_register,
  output logic [NUM_LEVELS-1:0] highest_level_in_service,
  output logic [2:0]            priority_rotate,
  output logic                  interrupt_out,
  output logic [NUM_LEVELS-1:0] clear_interrupt_request,
  output logic [7:0]            vector_out,
  output logic                  vector_out_enable
);

  state_e     state_q, state_d;
  logic       inta_q;
  logic [7:0] isr_q, isr_d;
  logic [2:0] rot_q, rot_d;
  logic       rot_aeoi_q, rot_aeoi_d;
  logic [2:0] level_q, level_d;
  logic       spur_q, spur_d;
  logic       int_q, int_d;
  logic [7:0] clr_q, clr_d;

  logic [7:0] cand, hlis, isr_mask;
  logic [7:0] set_m, clr_m;
  logic [2:0] cand_lvl, hlis_lvl;
  logic       fall, rise, eligible;

  assign fall     = inta_q & ~interrupt_acknowledge_n;
  assign rise     = ~inta_q & interrupt_acknowledge_n;
  assign isr_mask = special_mask_mode ? interrupt_mask : 8'h00;

  priority_resolver u_cand (
    .request_i (interrupt_request_register),
    .mask_i    (interrupt_mask),
    .rotate_i  (rot_q),
    .grant_o   (cand)
  );

  priority_resolver u_hlis (
    .request_i (isr_q),
    .mask_i    (isr_mask),
    .rotate_i  (rot_q),
    .grant_o   (hlis)
  );

  assign cand_lvl = onehot_to_level(cand);
  assign hlis_lvl = onehot_to_level(hlis);
  assign eligible = (|cand) && (~|hlis ||
    level_priority(cand_lvl, rot_q) < level_priority(hlis_lvl, rot_q));

  always_comb begin
    state_d    = state_q;
    rot_d      = rot_q;
    rot_aeoi_d = rot_aeoi_q;
    level_d    = level_q;
    spur_d     = spur_q;
    clr_d      = '0;
    set_m      = '0;
    clr_m      = '0;
    int_d      = eligible && (state_q == IDLE);
    unique case (state_q)
      IDLE: if (fall) begin
        state_d = ACK1;
        if (eligible) begin
          set_m   = cand;
          clr_d   = cand;
          level_d = cand_lvl;
          spur_d  = 1'b0;
        end else begin
          level_d = 3'd7;
          spur_d  = 1'b1;
        end
      end
      ACK1:  if (rise) state_d = WAIT2;
      WAIT2: if (fall) state_d = ACK2;
      ACK2: if (rise) begin
        state_d = IDLE;
        if (auto_eoi_config && !spur_q) begin
          clr_m = 8'b1 << level_q;
          if (rot_aeoi_q) rot_d = level_q;
        end
      end
      default: state_d = IDLE;
    endcase
    // OCW2 takes precedence over an AEOI rotation in the same cycle
    if (ocw2_write) begin
      case (ocw2_command)
        EOI_NONSPEC: clr_m = clr_m | hlis;
        EOI_SPEC:    clr_m = clr_m | (8'b1 << ocw2_level);
        ROT_NONSPEC: if (|hlis) begin
          clr_m = clr_m | hlis;
          rot_d = hlis_lvl;
        end
        ROT_SPEC: begin
          clr_m = clr_m | (8'b1 << ocw2_level);
          rot_d = ocw2_level;
        end
        SET_PRIO:     rot_d      = ocw2_level;
        AEOI_ROT_SET: rot_aeoi_d = 1'b1;
        AEOI_ROT_CLR: rot_aeoi_d = 1'b0;
        default: ;
      endcase
    end
    isr_d = (isr_q & ~clr_m) | set_m;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      inta_q     <= 1'b1;
      isr_q      <= '0;
      rot_q      <= 3'd7;
      rot_aeoi_q <= 1'b0;
      level_q    <= '0;
      spur_q     <= 1'b0;
      int_q      <= 1'b0;
      clr_q      <= '0;
    end else begin
      state_q    <= state_d;
      inta_q     <= interrupt_acknowledge_n;
      isr_q      <= isr_d;
      rot_q      <= rot_d;
      rot_aeoi_q <= rot_aeoi_d;
      level_q    <= level_d;
      spur_q     <= spur_d;
      int_q      <= int_d;
      clr_q      <= clr_d;
    end
  end

  assign vector_out_enable = ~reset & ~interrupt_acknowledge_n &
    ((state_q == WAIT2 && fall) || state_q == ACK2);
  assign vector_out = vector_out_enable ? {vector_base, level_q} : 8'h00;

  assign in_service_register      = isr_q;
  assign highest_level_in_service = hlis;
  assign priority_rotate          = rot_q;
  assign interrupt_out            = int_q;
  assign clear_interrupt_request  = clr_q;

endmodule

// File: doc/interrupt_acknowledge_sequencer.md
Name: interrupt_acknowledge_sequencer

Overview:
- Driving end of the 8259A in-service path. Sets bits in the in-service register (ISR) on the INTA handshake, places the vector on the data bus, and clears ISR bits on EOI/AEOI.
- Owns the priority-rotation state that the in-service and priority-resolution logic consume.
- Sits between the interrupt request register, the OCW2 decode, and the data-bus buffer.

Parameters:
- NUM_LEVELS, 8, number of interrupt levels; only 8 is supported.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- interrupt_acknowledge_n  in  1  INTA#, already synchronised to clock
- interrupt_request_register  in  8  pending requests from the IRR
- interrupt_mask  in  8  OCW1 mask
- special_mask_mode  in  1  special mask mode active
- auto_eoi_config  in  1  ICW4 AEOI
- vector_base  in  5  ICW2 T7..T3
- ocw2_write  in  1  one-cycle strobe: OCW2 written
- ocw2_command  in  3  {R,SL,EOI}
- ocw2_level  in  3  L2..L0
- in_service_register  out  8  current ISR
- highest_level_in_service  out  8  one-hot highest ISR bit after special mask and rotation
- priority_rotate  out  3  lowest-priority level
- interrupt_out  out  1  INT to CPU
- clear_interrupt_request  out  8  one-cycle pulse that clears the acknowledged IRR bit
- vector_out  out  8  vector byte
- vector_out_enable  out  1  drive data bus

Behaviour:
- Reset values: ISR=0, priority_rotate=7, rotate_on_aeoi=0, state=IDLE, all outputs 0.
- Reset mid-handshake aborts it; no vector is driven and no ISR bit is set.
- INTA edges: interrupt_acknowledge_n is registered each cycle. A falling edge is prev=1, cur=0; a rising edge is prev=0, cur=1.
- Priority rule: level priority = (level - priority_rotate - 1) mod 8; 0 is highest.
- Candidate request: IRR & ~interrupt_mask, resolved by the priority rule, one-hot.
- Candidate is eligible only if it is strictly higher priority than highest_level_in_service. In special mask mode, masked ISR bits are ignored for this comparison.
- interrupt_out is registered and updates one cycle after its inputs. It is high when an eligible candidate exists and state is IDLE.
- State machine:
  - IDLE: on INTA falling edge go to ACK1.
    - If an eligible candidate exists: set ISR bit, pulse clear_interrupt_request for that bit, latch its level.
    - If no candidate exists: latch level 7 (spurious). ISR and IRR are untouched.
  - ACK1: wait for INTA rising edge, then go to WAIT2.
  - WAIT2: on INTA falling edge go to ACK2.
    - vector_out = {vector_base, level}.
    - vector_out_enable = 1 while INTA is low.
  - ACK2: on INTA rising edge, vector_out_enable=0 and go to IDLE.
    - If auto_eoi_config and not spurious: clear the latched ISR bit.
    - If rotate_on_aeoi is also set: priority_rotate = that level.
- OCW2 on ocw2_write, by {R,SL,EOI}:
  - 001: non-specific EOI; clear the highest_level_in_service bit.
  - 011: specific EOI; clear bit ocw2_level.
  - 101: clear the highest bit; priority_rotate = that level.
  - 111: clear bit ocw2_level; priority_rotate = ocw2_level.
  - 110: priority_rotate = ocw2_level.
  - 100: rotate_on_aeoi = 1.
  - 000: rotate_on_aeoi = 0.
  - 010: no operation.
- Non-specific EOI with ISR=0 is a no-op, including no rotation.
- Simultaneous set and clear in one cycle (first INTA plus EOI): both are applied. If they target the same bit, the set wins.
- highest_level_in_service is combinational from ISR, the special mask, and priority_rotate. It is zero when no unmasked ISR bit is set.
- An INTA falling edge while in ACK1 or ACK2 (glitch) is ignored.

Decomposition:
- Shared package:
  - OCW2 command localparams (EOI_NONSPEC=3'b001, EOI_SPEC=3'b011, ROT_NONSPEC=3'b101, ROT_SPEC=3'b111, SET_PRIO=3'b110, AEOI_ROT_SET=3'b100, AEOI_ROT_CLR=3'b000)
  - state enum {IDLE, ACK1, WAIT2, ACK2}
  - rotate_right, rotate_left, resolv_priority and one-hot-to-level functions
- One sub-module: priority_resolver (mask, rotate, resolve, unrotate). It is instantiated twice: once for the IRR candidate and once for highest_level_in_service.

Test Plan:
- Reset, then IRR=0x24, mask=0, base=0x08: INT rises one cycle later. First INTA sets ISR=0x04 and pulses clear_interrupt_request=0x04. Second INTA gives vector_out=0x0A with enable high while INTA is low.
- ISR=0x04, IRR=0x01: INT=1 (IR0 higher). IRR=0x10: INT=0. OCW2=001: ISR=0x00, then INT=1.
- priority_rotate=7, ISR=0x0C, OCW2=101: ISR=0x08, priority_rotate=2, so IR3 is now highest.
- auto_eoi_config=1, OCW2=100, IRR=0x40: after the second INTA rising edge, ISR=0x00 and priority_rotate=6.
- INTA sequence with IRR=0: vector_out={base,3'b111}, ISR stays 0, clear_interrupt_request stays 0.
- Reset asserted during WAIT2: state=IDLE, vector_out_enable=0, ISR=0, priority_rotate=7 on the next cycle.
